// File: rtl/mc14500_pkg.sv
// Shared constants for the MC14500B program sequencer: opcodes, sequencer
// states and instruction-word layout.
package mc14500_pkg;

    localparam logic [3:0] OP_NOPO = 4'h0;
    localparam logic [3:0] OP_LD   = 4'h1;
    localparam logic [3:0] OP_LDC  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_ANDC = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_ORC  = 4'h6;
    localparam logic [3:0] OP_XNOR = 4'h7;
    localparam logic [3:0] OP_STO  = 4'h8;
    localparam logic [3:0] OP_STOC = 4'h9;
    localparam logic [3:0] OP_IEN  = 4'hA;
    localparam logic [3:0] OP_OEN  = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_RTN  = 4'hD;
    localparam logic [3:0] OP_SKZ  = 4'hE;
    localparam logic [3:0] OP_NOPF = 4'hF;

    typedef enum logic [1:0] {IDLE, RUN, BUBBLE, HALT} seq_state_t;

    // Instruction word is {opcode, operand}; the opcode sits above the
    // PC_W-bit operand, so its LSB offset equals PC_W.
    localparam int OPC_W   = 4;
    localparam int OPR_LSB = 0;

endpackage

// File: rtl/mc14500_seq_if.sv
// Sequencer <-> ICU link: opcode/run/data towards the ICU, control strobes back.
interface mc14500_seq_if;
    logic [3:0] I;
    logic       run;
    logic       DATA;
    logic       WRITE;
    logic       DATA_OUT;
    logic       JMP;
    logic       RTN;
    logic       FLAG_F;

    modport master (output I, run, DATA,
                    input  WRITE, DATA_OUT, JMP, RTN, FLAG_F);
    modport slave  (input  I, run, DATA,
                    output WRITE, DATA_OUT, JMP, RTN, FLAG_F);
endinterface

// File: rtl/mc14500_rtn_stack.sv
// Return-address LIFO; overflow/underflow requests are silently ignored here.
module mc14500_rtn_stack #(
    parameter  int PC_W  = 8,
    parameter  int STK_D = 4,
    localparam int SP_W  = $clog2(STK_D + 1)
) (
    input  logic            clk,
    input  logic            RST,
    input  logic            clr,
    input  logic            push,
    input  logic            pop,
    input  logic [PC_W-1:0] din,
    output logic [PC_W-1:0] dout,
    output logic [SP_W-1:0] sp,
    output logic            full,
    output logic            empty
);
    localparam int IDX_W = (STK_D > 1) ? $clog2(STK_D) : 1;

    logic [PC_W-1:0] mem [2**IDX_W];
    logic [SP_W-1:0] sp_dec;

    assign sp_dec = sp - 1'b1;
    assign full   = (sp == SP_W'(STK_D));
    assign empty  = (sp == '0);
    assign dout   = mem[sp_dec[IDX_W-1:0]];

    // Contents survive clr and reset; only the occupancy count is cleared.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[sp[IDX_W-1:0]] <= din;
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            sp <= '0;
        else if (clr)
            sp <= '0;
        else if (push && !full)
            sp <= sp + 1'b1;
        else if (pop && !empty)
            sp <= sp - 1'b1;
    end
endmodule

// File: rtl/mc14500_seq.sv
// Program sequencer and bit-addressed I/O block driving an MC14500B ICU.
//
//  state  | meaning
//  IDLE   | stopped, run=0, pc held, waiting for start
//  RUN    | executing; acts on FLAG_F/JMP/RTN from the ICU
//  BUBBLE | ICU stall after JMP/RTN; pc held so the target is re-presented
//  HALT   | FLAG_F seen, run=0, pc held, start restarts from 0
module mc14500_seq
    import mc14500_pkg::*;
#(
    parameter int PC_W  = 8,
    parameter int IO_AW = 4,
    parameter int STK_D = 4
) (
    input  logic                       clk,
    input  logic                       RST,
    input  logic                       start,
    input  logic                       stop,
    output logic [PC_W-1:0]            prog_addr,
    input  logic [OPC_W+PC_W-1:0]      prog_data,
    mc14500_seq_if.master              icu,
    input  logic [2**IO_AW-1:0]        in_bits,
    output logic [2**IO_AW-1:0]        out_bits,
    output logic                       halted,
    output logic                       stk_err,
    output logic [$clog2(STK_D+1)-1:0] sp
);
    localparam logic [1:0] ST_IDLE   = 2'(IDLE);
    localparam logic [1:0] ST_RUN    = 2'(RUN);
    localparam logic [1:0] ST_BUBBLE = 2'(BUBBLE);
    localparam logic [1:0] ST_HALT   = 2'(HALT);

    logic [1:0]       state;
    logic [PC_W-1:0]  pc;
    logic [PC_W-1:0]  pc_inc;
    logic [3:0]       opcode;
    logic [PC_W-1:0]  operand;
    logic [IO_AW-1:0] io_addr;
    logic             active;
    logic             restart;
    logic             exec;
    logic             stk_push;
    logic             stk_pop;
    logic [PC_W-1:0]  stk_dout;
    logic             stk_full;
    logic             stk_empty;

    assign opcode    = prog_data[PC_W +: OPC_W];
    assign operand   = prog_data[OPR_LSB +: PC_W];
    assign io_addr   = operand[IO_AW-1:0];
    assign pc_inc    = pc + 1'b1;
    assign prog_addr = pc;

    assign active  = (state == ST_RUN) || (state == ST_BUBBLE);
    assign restart = start && ((state == ST_IDLE) || (state == ST_HALT));
    // ICU strobes only count in RUN and only if nothing of higher priority fires.
    assign exec     = (state == ST_RUN) && !stop && !icu.FLAG_F;
    assign stk_push = exec && icu.JMP;
    assign stk_pop  = exec && !icu.JMP && icu.RTN;

    assign icu.run  = active;
    assign icu.I    = active ? opcode : OP_NOPO;
    assign icu.DATA = in_bits[io_addr];
    assign halted   = (state == ST_HALT);

    mc14500_rtn_stack #(.PC_W(PC_W), .STK_D(STK_D)) u_stack (
        .clk   (clk),
        .RST   (RST),
        .clr   (restart),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (pc_inc),
        .dout  (stk_dout),
        .sp    (sp),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state   <= ST_IDLE;
            pc      <= '0;
            stk_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE, ST_HALT: begin
                    if (start) begin
                        state   <= ST_RUN;
                        pc      <= '0;
                        stk_err <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state <= ST_IDLE;
                    end else if (icu.FLAG_F) begin
                        state <= ST_HALT;
                        pc    <= pc_inc;
                    end else if (icu.JMP) begin
                        if (stk_full)
                            stk_err <= 1'b1;
                        pc    <= operand;
                        state <= ST_BUBBLE;
                    end else if (icu.RTN) begin
                        if (stk_empty) begin
                            stk_err <= 1'b1;
                            pc      <= pc_inc;
                        end else begin
                            pc <= stk_dout;
                        end
                        state <= ST_BUBBLE;
                    end else begin
                        pc <= pc_inc;
                    end
                end
                ST_BUBBLE: state <= stop ? ST_IDLE : ST_RUN;
                default:   state <= ST_IDLE;
            endcase
        end
    end

    // Stores complete in any state so an in-flight ICU write is never lost.
    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            out_bits <= '0;
        else if (icu.WRITE)
            out_bits[io_addr] <= icu.DATA_OUT;
    end
endmodule
